// File: rtl/pipe_pkg.sv
// Shared constants and types for the fetch stage and the IF/ID and ID/EX boundary.
package pipe_pkg;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_XORI = 6'b001110;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_NOP = '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: the fetch stage drives the address, memory answers combinationally.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, load enable, synchronous flush (flush beats load).
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] flush_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q <= RST_VAL;
    else if (flush) q <= flush_val;
    else if (load)  q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID and ID/EX registers, driven by the load-use hazard controls.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt ports.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          CTRL_W      = 10,
  parameter int          MEMREAD_BIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              PC_WriteEn,
  input  logic              IFID_WriteEn,
  input  logic              Stall_flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  fetch_stage_if.master     imem,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc4,
  output logic              id_valid,
  output logic [5:0]        ID_Op,
  output logic [4:0]        ID_rs,
  output logic [4:0]        ID_rt,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [4:0]        EX_rt,
  output logic              EX_MemRead
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  logic [31:0] pc_q, pc4, pc_d;
  ifid_t       ifid_d, ifid_q;
  logic        ifid_flush, idex_bubble;

  // A stalled PC ignores branch_taken; the branch re-resolves once the stall lifts.
  assign pc4  = pc_q + 32'd4;
  assign pc_d = branch_taken ? branch_target : pc4;

  pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk, .reset_n, .load(PC_WriteEn), .flush(1'b0), .flush_val('0),
    .d(pc_d), .q(pc_q)
  );

  assign imem.imem_addr = pc_q;

  assign ifid_flush = IFID_WriteEn & branch_taken;
  assign ifid_d     = '{inst: imem.imem_rdata, pc4: pc4, valid: 1'b1};

  pipe_reg #(.W($bits(ifid_t)), .RST_VAL(IFID_NOP)) u_ifid (
    .clk, .reset_n, .load(IFID_WriteEn), .flush(ifid_flush), .flush_val(IFID_NOP),
    .d(ifid_d), .q(ifid_q)
  );

  assign id_inst  = ifid_q.inst;
  assign id_pc4   = ifid_q.pc4;
  assign id_valid = ifid_q.valid;
  assign ID_Op    = id_inst[OP_MSB:OP_LSB];
  assign ID_rs    = id_inst[RS_MSB:RS_LSB];
  assign ID_rt    = id_inst[RT_MSB:RT_LSB];

  // ID/EX loads every edge; a bubble is just a zeroed control word.
  assign idex_bubble = Stall_flush | ~id_valid;

  pipe_reg #(.W(CTRL_W), .RST_VAL('0)) u_idex_ctrl (
    .clk, .reset_n, .load(1'b1), .flush(idex_bubble), .flush_val('0),
    .d(id_ctrl), .q(idex_ctrl)
  );

  pipe_reg #(.W(5), .RST_VAL('0)) u_idex_rt (
    .clk, .reset_n, .load(1'b1), .flush(1'b0), .flush_val('0),
    .d(ID_rt), .q(EX_rt)
  );

  assign EX_MemRead = idex_ctrl[MEMREAD_BIT];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Stall_flush && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush  && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // Counters compiled out; datapath is unchanged.
`endif
endmodule
